adder_const_iter: RTL and testbench

- Iterated, parametrised successor of the single-round constant adder.
- Accepts a 320-bit Ascon state and a round count (6, 8 or 12), then applies the constant-addition layer for every round of p^a, UNROLL rounds per clock.
- Returns the state with a valid/ready handshake.
- Sits between the state register and the permutation controller; it also serves as the round-index source and timing reference for the upcoming sequential permutation.

---
 rtl/ascon_pkg.sv | 31 +++
 rtl/adder_const_iter_unit.sv | 38 +++
 rtl/adder_const_iter.sv | 113 +++++++++++
 tb/tb_adder_const_iter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared Ascon types and constants for the constant-addition datapath.
package ascon_pkg;

  localparam int unsigned LANE_W        = 64;
  localparam int unsigned NB_LANES      = 5;
  localparam int unsigned NB_ROUNDS_MAX = 12;
  localparam int unsigned ROUND_W       = 4;
  localparam int unsigned RC_W          = 8;
  localparam int unsigned RC_LANE       = 2;

  // Five 64-bit lanes; lane 0 in the lowest slot.
  typedef logic [NB_LANES-1:0][LANE_W-1:0] t_state_array;

  // Round constants of p^12, indexed by absolute round number.
  localparam logic [RC_W-1:0] ROUND_CONSTANTS [0:NB_ROUNDS_MAX-1] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } t_const_fsm;

  // Arithmetic form of the round constant: high nibble 0xF-r, low nibble r.
  function automatic logic [RC_W-1:0] round_constant(input logic [ROUND_W-1:0] r);
    return {4'hF - r, r};
  endfunction

endpackage

// File: rtl/adder_const_iter_unit.sv
// Combinational constant-addition layer: applies UNROLL consecutive round
// constants starting at round_i to lane 2. Build option ADDER_CONST_LUT_EN
// selects the table lookup instead of the arithmetic constant.
module adder_const_unit
  import ascon_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic [ROUND_W-1:0] round_i,
  input  t_state_array       state_i,
  output t_state_array       state_o
);

  // Constant for one round; rounds past the end contribute nothing.
  function automatic logic [RC_W-1:0] rc_at(input logic [ROUND_W-1:0] r);
    if (32'(r) >= NB_ROUNDS_MAX) begin
      return '0;
    end
`ifdef ADDER_CONST_LUT_EN
    return ROUND_CONSTANTS[r];
`else
    return round_constant(r);
`endif
  endfunction

  logic [RC_W-1:0] rc_sum;

  // XOR-fold the constants of this step and apply them to lane 2's low byte.
  always_comb begin
    rc_sum  = '0;
    state_o = state_i;
    for (int unsigned u = 0; u < UNROLL; u++) begin
      rc_sum = rc_sum ^ rc_at(round_i + ROUND_W'(u));
    end
    state_o[RC_LANE][RC_W-1:0] = state_i[RC_LANE][RC_W-1:0] ^ rc_sum;
  end

endmodule

// File: rtl/adder_const_iter.sv
// Iterated Ascon constant-addition block: accepts a state and round count,
// applies UNROLL rounds per clock, returns the result over valid/ready.
// Build option: ADDER_CONST_LUT_EN (table-based constants in the unit).
module adder_const_iter
  import ascon_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [ROUND_W-1:0] i_n_rounds,
  input  t_state_array       i_state,
  input  logic               i_clear,
  output logic               o_valid,
  input  logic               i_ready,
  output t_state_array       o_state,
  output logic [ROUND_W-1:0] o_round,
  output logic               o_busy
);

  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("adder_const_iter: UNROLL must be 1 or 2");
  end

  t_const_fsm         state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d, round_inc;
  t_state_array       data_q, data_d, data_upd;
  logic               ready_q, busy_q, valid_q;

  // Unsupported round counts fall back to the full permutation.
  function automatic logic [ROUND_W-1:0] eff_rounds(input logic [ROUND_W-1:0] n);
    case (n)
      4'd6, 4'd8, 4'd12: return n;
      default:           return ROUND_W'(NB_ROUNDS_MAX);
    endcase
  endfunction

  adder_const_unit #(
    .UNROLL (UNROLL)
  ) u_unit (
    .round_i (round_q),
    .state_i (data_q),
    .state_o (data_upd)
  );

  assign round_inc = round_q + ROUND_W'(UNROLL);

  // Next-state, counter and datapath selection; clear overrides everything.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          data_d  = i_state;
          round_d = ROUND_W'(NB_ROUNDS_MAX) - eff_rounds(i_n_rounds);
          state_d = RUN;
        end
      end
      RUN: begin
        data_d = data_upd;
        if (round_inc >= ROUND_W'(NB_ROUNDS_MAX)) begin
          round_d = ROUND_W'(NB_ROUNDS_MAX);
          state_d = DONE;
        end else begin
          round_d = round_inc;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (i_clear) begin
      state_d = IDLE;
      round_d = '0;
      data_d  = data_q;
    end
  end

  // State, counter, data and decoded handshake flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      round_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      data_q  <= data_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d == RUN);
      valid_q <= (state_d == DONE);
    end
  end

  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_state = data_q;
  assign o_round = round_q;

endmodule

// File: tb/tb_adder_const_iter.sv
// Bench for adder_const_iter: UNROLL=1 and UNROLL=2 instances driven in
// lockstep, checked against a scoreboard of expected states.
module tb_adder_const_iter;
  import ascon_pkg::*;

  localparam logic [7:0] RC_TAB [12] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  logic         clock = 1'b0;
  logic         reset_n;
  logic         i_valid, i_clear, i_ready;
  logic [3:0]   i_n_rounds;
  t_state_array i_state;

  logic         o_ready1, o_valid1, o_busy1, o_ready2, o_valid2, o_busy2;
  logic [3:0]   o_round1, o_round2;
  t_state_array o_state1, o_state2;

  int tests = 0;
  int fails = 0;
  t_state_array q1[$];
  t_state_array q2[$];

  always #5 clock = ~clock;

  adder_const_iter #(.UNROLL(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .i_valid(i_valid), .o_ready(o_ready1),
    .i_n_rounds(i_n_rounds), .i_state(i_state), .i_clear(i_clear),
    .o_valid(o_valid1), .i_ready(i_ready), .o_state(o_state1),
    .o_round(o_round1), .o_busy(o_busy1)
  );

  adder_const_iter #(.UNROLL(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .i_valid(i_valid), .o_ready(o_ready2),
    .i_n_rounds(i_n_rounds), .i_state(i_state), .i_clear(i_clear),
    .o_valid(o_valid2), .i_ready(i_ready), .o_state(o_state2),
    .o_round(o_round2), .o_busy(o_busy2)
  );

  task automatic chk_v(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input t_state_array obs, input t_state_array exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic int neff(input logic [3:0] n);
    return (n == 4'd6 || n == 4'd8 || n == 4'd12) ? int'(n) : 12;
  endfunction

  // Reference: sequential single-round constant additions.
  function automatic t_state_array model(input t_state_array st, input int start, input int nr);
    t_state_array s;
    s = st;
    for (int r = 0; r < nr; r++) s[2][7:0] = s[2][7:0] ^ RC_TAB[start + r];
    return s;
  endfunction

  function automatic t_state_array rnd_state();
    return t_state_array'({10{$urandom()}});
  endfunction

  // One-cycle acceptance; returns at the negedge after the accepting edge.
  task automatic accept(input logic [3:0] n, input t_state_array st);
    @(negedge clock);
    i_valid = 1'b1; i_n_rounds = n; i_state = st;
    @(negedge clock);
    i_valid = 1'b0; i_state = rnd_state(); i_n_rounds = 4'($urandom_range(0, 15));
  endtask

  task automatic run_txn(input string tag, input logic [3:0] n, input t_state_array st,
                         input t_state_array exp, input int hold);
    int ne, lat1, lat2;
    t_state_array e1, e2;
    ne = neff(n);
    q1.push_back(exp);
    q2.push_back(exp);
    chk_v({tag, "_ready1"}, 64'(o_ready1), 64'd1);
    chk_v({tag, "_ready2"}, 64'(o_ready2), 64'd1);
    accept(n, st);
    chk_v({tag, "_busy1"}, 64'(o_busy1), 64'd1);
    chk_v({tag, "_round1_start"}, 64'(o_round1), 64'(12 - ne));
    chk_v({tag, "_round2_start"}, 64'(o_round2), 64'(12 - ne));
    lat1 = -1; lat2 = -1;
    for (int c = 1; c <= 20 && (lat1 < 0 || lat2 < 0); c++) begin
      @(negedge clock);
      if (o_valid1 && lat1 < 0) lat1 = c;
      if (o_valid2 && lat2 < 0) lat2 = c;
    end
    chk_v({tag, "_lat1"}, 64'(lat1), 64'(ne));
    chk_v({tag, "_lat2"}, 64'(lat2), 64'(ne / 2));
    e1 = q1.pop_front();
    e2 = q2.pop_front();
    chk_s({tag, "_state1"}, o_state1, e1);
    chk_s({tag, "_state2"}, o_state2, e2);
    chk_v({tag, "_round1_end"}, 64'(o_round1), 64'd12);
    chk_v({tag, "_round2_end"}, 64'(o_round2), 64'd12);
    // Backpressure: result must hold and a second request must be ignored.
    if (hold > 0) begin
      i_valid = 1'b1; i_state = ~st; i_n_rounds = 4'd6;
      for (int h = 0; h < hold; h++) begin
        @(negedge clock);
        chk_s({tag, "_hold_state1"}, o_state1, e1);
        chk_s({tag, "_hold_state2"}, o_state2, e2);
        chk_v({tag, "_hold_ready1"}, 64'(o_ready1), 64'd0);
        chk_v({tag, "_hold_valid2"}, 64'(o_valid2), 64'd1);
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    chk_v({tag, "_ready1_in_done"}, 64'(o_ready1), 64'd0);
    @(negedge clock);
    i_ready = 1'b0;
    chk_v({tag, "_ready1_after"}, 64'(o_ready1), 64'd1);
    chk_v({tag, "_ready2_after"}, 64'(o_ready2), 64'd1);
    chk_v({tag, "_valid1_after"}, 64'(o_valid1), 64'd0);
    chk_v({tag, "_busy2_after"}, 64'(o_busy2), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    t_state_array st, ex;
    logic [3:0] n;
    logic [3:0] nlist [6];
    nlist = '{4'd6, 4'd8, 4'd12, 4'd0, 4'd15, 4'd7};

    reset_n = 1'b0; i_valid = 1'b0; i_clear = 1'b0; i_ready = 1'b0;
    i_n_rounds = 4'd0; i_state = '0;
    @(negedge clock); @(negedge clock);
    chk_v("rst_valid1", 64'(o_valid1), 64'd0);
    chk_v("rst_busy1", 64'(o_busy1), 64'd0);
    chk_v("rst_round2", 64'(o_round2), 64'd0);
    chk_s("rst_state1", o_state1, '0);
    reset_n = 1'b1;
    @(negedge clock);
    chk_v("rst_ready1", 64'(o_ready1), 64'd1);
    chk_v("rst_ready2", 64'(o_ready2), 64'd1);

    // Directed cases with literal expected results.
    run_txn("n12_zero", 4'd12, '0, '0, 0);
    ex = '0; ex[2] = 64'h11;
    run_txn("n6_zero", 4'd6, '0, ex, 0);
    run_txn("n8_zero", 4'd8, '0, '0, 0);
    st = rnd_state(); st[2] = 64'hFFFF_FFFF_FFFF_FF00;
    ex = st;          ex[2] = 64'hFFFF_FFFF_FFFF_FF11;
    run_txn("n6_ff_bp", 4'd6, st, ex, 5);
    st = rnd_state(); st[2] = 64'h0123_4567_89AB_CD00;
    run_txn("n5_as12", 4'd5, st, st, 1);

    // Abort after a few RUN cycles: back to IDLE, data kept, never valid.
    st = rnd_state();
    accept(4'd12, st);
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      chk_v("abort_novalid1", 64'(o_valid1), 64'd0);
      chk_v("abort_novalid2", 64'(o_valid2), 64'd0);
    end
    i_clear = 1'b1;
    @(negedge clock);
    i_clear = 1'b0;
    chk_v("abort_ready1", 64'(o_ready1), 64'd1);
    chk_v("abort_busy2", 64'(o_busy2), 64'd0);
    chk_v("abort_valid1", 64'(o_valid1), 64'd0);
    chk_v("abort_round1", 64'(o_round1), 64'd0);
    chk_v("abort_round2", 64'(o_round2), 64'd0);
    chk_s("abort_state1", o_state1, model(st, 0, 2));
    chk_s("abort_state2", o_state2, model(st, 0, 4));
    @(negedge clock);
    chk_v("abort_idle_busy1", 64'(o_busy1), 64'd0);

    // Asynchronous reset in the middle of RUN.
    st = rnd_state();
    accept(4'd8, st);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk_v("arst_busy1", 64'(o_busy1), 64'd0);
    chk_v("arst_valid2", 64'(o_valid2), 64'd0);
    chk_v("arst_round1", 64'(o_round1), 64'd0);
    chk_s("arst_state1", o_state1, '0);
    chk_s("arst_state2", o_state2, '0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk_v("arst_ready1", 64'(o_ready1), 64'd1);
    chk_v("arst_valid1", 64'(o_valid1), 64'd0);

    // Random states and round counts against the reference model.
    for (int i = 0; i < 12; i++) begin
      n  = nlist[$urandom_range(0, 5)];
      st = rnd_state();
      ex = model(st, 12 - neff(n), neff(n));
      run_txn("rnd", n, st, ex, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
